// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: bus widths, hold codes
// and FSM states.
package pipe_ctrl_pkg;

  localparam int unsigned InstAddrW = 32;
  localparam int unsigned RegsAddrW = 5;

  localparam logic [InstAddrW-1:0] ZeroWord = '0;
  localparam logic [RegsAddrW-1:0] Reg0Addr = '0;

  typedef enum logic [2:0] {
    HoldNone = 3'd0,
    HoldPc   = 3'd1,
    HoldIf   = 3'd2,
    HoldId   = 3'd3
  } hold_e;

  typedef enum logic [1:0] {
    PipeRun = 2'd0,
    PipeDiv = 2'd1,
    PipeMem = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Event inputs and hold/flush/jump outputs of pipe_ctrl. The master side is the pipeline
// (EX/ID stages and bus), the slave side is the controller.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic                 i_jump_req;
  logic [InstAddrW-1:0] i_jump_addr;
  logic                 i_ex_is_load;
  logic [RegsAddrW-1:0] i_ex_rd_addr;
  logic [RegsAddrW-1:0] i_id_rs1_addr;
  logic [RegsAddrW-1:0] i_id_rs2_addr;
  logic                 i_id_rs1_used;
  logic                 i_id_rs2_used;
  logic                 i_div_start;
  logic                 i_div_done;
  logic                 i_mem_req;
  logic                 i_mem_ready;

  logic [2:0]           o_hold_flag;
  logic                 o_flush_if;
  logic                 o_flush_id;
  logic                 o_jump_flag;
  logic [InstAddrW-1:0] o_jump_addr;
  logic                 o_bus_err;

  modport master (
    output i_jump_req, i_jump_addr, i_ex_is_load, i_ex_rd_addr, i_id_rs1_addr, i_id_rs2_addr,
    output i_id_rs1_used, i_id_rs2_used, i_div_start, i_div_done, i_mem_req, i_mem_ready,
    input  o_hold_flag, o_flush_if, o_flush_id, o_jump_flag, o_jump_addr, o_bus_err
  );

  modport slave (
    input  i_jump_req, i_jump_addr, i_ex_is_load, i_ex_rd_addr, i_id_rs1_addr, i_id_rs2_addr,
    input  i_id_rs1_used, i_id_rs2_used, i_div_start, i_div_done, i_mem_req, i_mem_ready,
    output o_hold_flag, o_flush_if, o_flush_id, o_jump_flag, o_jump_addr, o_bus_err
  );

endinterface

// File: rtl/pipe_hazard_det.sv
// Load-use comparator: flags an ID source register that matches the rd of a load in EX.
module pipe_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic                 i_ex_is_load,
  input  logic [RegsAddrW-1:0] i_ex_rd_addr,
  input  logic [RegsAddrW-1:0] i_id_rs1_addr,
  input  logic [RegsAddrW-1:0] i_id_rs2_addr,
  input  logic                 i_id_rs1_used,
  input  logic                 i_id_rs2_used,
  output logic                 o_load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr);
  assign rs2_hit = i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr);

  // x0 is hardwired to zero, so a load targeting it never produces a dependency.
  assign o_load_use = i_ex_is_load && (i_ex_rd_addr != Reg0Addr) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: jump flush, load-use bubble and multi-cycle EX stalls.
// Optional bus timeout compiled in with PIPE_CTRL_TIMEOUT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic         i_Clk,
  input logic         i_reset,
  pipe_ctrl_if.slave  bus
);

  if (MEM_TIMEOUT < 2) begin : g_param_chk
    $error("MEM_TIMEOUT must be at least 2");
  end

  pipe_state_e state_q, state_d;
  hold_e       hold;
  logic        load_use;
  logic        timeout;

  pipe_hazard_det u_hazard_det (
    .i_ex_is_load  (bus.i_ex_is_load),
    .i_ex_rd_addr  (bus.i_ex_rd_addr),
    .i_id_rs1_addr (bus.i_id_rs1_addr),
    .i_id_rs2_addr (bus.i_id_rs2_addr),
    .i_id_rs1_used (bus.i_id_rs1_used),
    .i_id_rs2_used (bus.i_id_rs2_used),
    .o_load_use    (load_use)
  );

`ifdef PIPE_CTRL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;

  // cnt_inc counts the current S_MEM cycle, so the abort lands on stall MEM_TIMEOUT
  // when the S_RUN request cycle is counted as the first stall.
  assign cnt_inc = cnt_q + 1'b1;
  assign timeout = (state_q == PipeMem) && !bus.i_mem_ready &&
                   (cnt_inc == CntW'(MEM_TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == PipeMem && !bus.i_mem_ready && !timeout) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    hold            = HoldNone;
    bus.o_flush_if  = 1'b0;
    bus.o_flush_id  = 1'b0;
    bus.o_jump_flag = 1'b0;
    bus.o_jump_addr = ZeroWord;
    bus.o_bus_err   = 1'b0;
    state_d         = state_q;
    if (!i_reset) begin
      state_d = PipeRun;
    end else begin
      unique case (state_q)
        PipeRun: begin
          if (bus.i_jump_req) begin
            bus.o_jump_flag = 1'b1;
            bus.o_jump_addr = bus.i_jump_addr;
            bus.o_flush_if  = 1'b1;
            bus.o_flush_id  = 1'b1;
          end else if (bus.i_div_start && !bus.i_div_done) begin
            hold    = HoldId;
            state_d = PipeDiv;
          end else if (bus.i_mem_req && !bus.i_mem_ready) begin
            hold    = HoldId;
            state_d = PipeMem;
          end else if (load_use) begin
            hold           = HoldIf;
            bus.o_flush_id = 1'b1;
          end
        end
        PipeDiv: begin
          if (bus.i_div_done) begin
            state_d = PipeRun;
          end else begin
            hold = HoldId;
          end
        end
        PipeMem: begin
          if (timeout) begin
            bus.o_bus_err = 1'b1;
            state_d       = PipeRun;
          end else if (bus.i_mem_ready) begin
            state_d = PipeRun;
          end else begin
            hold = HoldId;
          end
        end
        default: state_d = PipeRun;
      endcase
    end
  end

  assign bus.o_hold_flag = hold;

  always_ff @(posedge i_Clk) begin
    if (!i_reset) begin
      state_q <= PipeRun;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: vector table, hand-written stall/reset sequences and random
// stimulus against a stall-accounting reference model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned MemTimeout = 8;

  typedef struct packed {
    logic [2:0]  hold;
    logic        fif;
    logic        fid;
    logic        jf;
    logic [31:0] addr;
    logic        err;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic        jr;
    logic [31:0] ja;
    logic        ld;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        ds;
    logic        dd;
    logic        mr;
    logic        my;
    out_t        exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Model: 0 = free-running, 1 = waiting on divider, 2 = waiting on bus.
  int   m_unit  = 0;
  int   m_stall = 0;
  out_t last_out;

  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .MEM_TIMEOUT (MemTimeout)
  ) dut (
    .i_Clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  task automatic check(input string name, input out_t act, input out_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got hold=%0d fif=%b fid=%b jf=%b addr=%h err=%b, want hold=%0d fif=%b fid=%b jf=%b addr=%h err=%b",
               name, act.hold, act.fif, act.fid, act.jf, act.addr, act.err,
               req.hold, req.fif, req.fid, req.jf, req.addr, req.err);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  function automatic out_t read_dut();
    out_t o;
    o.hold = bus.o_hold_flag;
    o.fif  = bus.o_flush_if;
    o.fid  = bus.o_flush_id;
    o.jf   = bus.o_jump_flag;
    o.addr = bus.o_jump_addr;
    o.err  = bus.o_bus_err;
    return o;
  endfunction

  task automatic eval_model(output out_t e, output int nu, output int ns);
    logic hz;
    logic to;
    e  = '0;
    nu = 0;
    ns = 0;
    to = 1'b0;
    hz = bus.i_ex_is_load && (bus.i_ex_rd_addr != 0) &&
         ((bus.i_id_rs1_used && bus.i_id_rs1_addr == bus.i_ex_rd_addr) ||
          (bus.i_id_rs2_used && bus.i_id_rs2_addr == bus.i_ex_rd_addr));
    if (!rst_n) return;
    if (m_unit == 0) begin
      if (bus.i_jump_req) begin
        e.jf = 1; e.fif = 1; e.fid = 1; e.addr = bus.i_jump_addr;
      end else if (bus.i_div_start && !bus.i_div_done) begin
        e.hold = 3; nu = 1;
      end else if (bus.i_mem_req && !bus.i_mem_ready) begin
        e.hold = 3; nu = 2; ns = 1;
      end else if (hz) begin
        e.hold = 2; e.fid = 1;
      end
    end else if (m_unit == 1) begin
      if (!bus.i_div_done) begin
        e.hold = 3; nu = 1;
      end
    end else begin
`ifdef PIPE_CTRL_TIMEOUT_EN
      to = !bus.i_mem_ready && (m_stall + 1 == int'(MemTimeout));
`endif
      if (to) begin
        e.err = 1;
      end else if (!bus.i_mem_ready) begin
        e.hold = 3; nu = 2; ns = m_stall + 1;
      end
    end
  endtask

  // Compare the current cycle against the model, then advance one clock.
  task automatic cycle(input string name);
    out_t e;
    int   nu, ns;
    #1;
    eval_model(e, nu, ns);
    last_out = read_dut();
    check(name, last_out, e);
    @(posedge clk);
    m_unit  = nu;
    m_stall = ns;
    #1;
  endtask

  task automatic idle();
    bus.i_jump_req    = 0; bus.i_jump_addr   = '0; bus.i_ex_is_load  = 0;
    bus.i_ex_rd_addr  = '0; bus.i_id_rs1_addr = '0; bus.i_id_rs2_addr = '0;
    bus.i_id_rs1_used = 0; bus.i_id_rs2_used = 0; bus.i_div_start   = 0;
    bus.i_div_done    = 0; bus.i_mem_req     = 0; bus.i_mem_ready   = 0;
  endtask

  task automatic apply(input vec_t v);
    rst_n             = v.rst;
    bus.i_jump_req    = v.jr;  bus.i_jump_addr   = v.ja;  bus.i_ex_is_load = v.ld;
    bus.i_ex_rd_addr  = v.rd;  bus.i_id_rs1_addr = v.rs1; bus.i_id_rs2_addr = v.rs2;
    bus.i_id_rs1_used = v.u1;  bus.i_id_rs2_used = v.u2;  bus.i_div_start  = v.ds;
    bus.i_div_done    = v.dd;  bus.i_mem_req     = v.mr;  bus.i_mem_ready  = v.my;
  endtask

  function automatic out_t mk_out(logic [2:0] h, logic fif, logic fid, logic jf,
                                  logic [31:0] a);
    out_t o;
    o.hold = h; o.fif = fif; o.fid = fid; o.jf = jf; o.addr = a; o.err = 1'b0;
    return o;
  endfunction

  initial begin
    vec_t tbl[$];
    vec_t v;
    out_t e;
    int   nu, ns;
    int   cnt;
    int   err_at;

    idle();
    @(posedge clk); #1;
    cycle("reset0");
    cycle("reset1");
    rst_n = 1;

    // Vector table: every entry starts and ends in S_RUN.
    v = '0; v.rst = 1;                                                      tbl.push_back(v);
    v = '0; v.rst = 1; v.jr = 1; v.ja = 32'h0000_0100;
    v.exp = mk_out(0, 1, 1, 1, 32'h0000_0100);                              tbl.push_back(v);
    v = '0; v.rst = 1; v.ld = 1; v.rd = 5; v.rs2 = 5; v.u2 = 1;
    v.exp = mk_out(2, 0, 1, 0, 0);                                          tbl.push_back(v);
    v = '0; v.rst = 1; v.ld = 1; v.rd = 0; v.rs2 = 0; v.u2 = 1;             tbl.push_back(v);
    v = '0; v.rst = 1; v.ld = 1; v.rd = 5; v.rs2 = 5; v.u2 = 0;             tbl.push_back(v);
    v = '0; v.rst = 1; v.ld = 1; v.rd = 7; v.rs1 = 7; v.u1 = 1;
    v.exp = mk_out(2, 0, 1, 0, 0);                                          tbl.push_back(v);
    v = '0; v.rst = 1; v.ld = 0; v.rd = 7; v.rs1 = 7; v.u1 = 1;             tbl.push_back(v);
    v = '0; v.rst = 1; v.ld = 1; v.rd = 7; v.rs1 = 6; v.rs2 = 8; v.u1 = 1; v.u2 = 1;
                                                                            tbl.push_back(v);
    v = '0; v.rst = 1; v.ds = 1; v.dd = 1;                                  tbl.push_back(v);
    v = '0; v.rst = 1; v.mr = 1; v.my = 1;                                  tbl.push_back(v);
    v = '0; v.rst = 1; v.jr = 1; v.ja = 32'hdead_beef; v.ld = 1; v.rd = 3; v.rs1 = 3; v.u1 = 1;
    v.exp = mk_out(0, 1, 1, 1, 32'hdead_beef);                              tbl.push_back(v);
    v = '0; v.rst = 0; v.jr = 1; v.ja = 32'h1234_5678; v.ds = 1;            tbl.push_back(v);

    foreach (tbl[i]) begin
      apply(tbl[i]);
      #1;
      check($sformatf("vec%0d", i), read_dut(), tbl[i].exp);
      eval_model(e, nu, ns);
      @(posedge clk);
      m_unit = nu; m_stall = ns;
      #1;
    end
    rst_n = 1;
    idle();

    // Priority: jump beats divide; next cycle must not be held.
    bus.i_jump_req = 1; bus.i_jump_addr = 32'h0000_0200; bus.i_div_start = 1;
    cycle("prio_jump");
    idle();
    cycle("prio_after");
    check_int("prio_no_hold", int'(last_out.hold), 0);

    // Load-use bubble lasts exactly one cycle once the load leaves EX.
    cnt = 0;
    bus.i_ex_is_load = 1; bus.i_ex_rd_addr = 5; bus.i_id_rs2_addr = 5; bus.i_id_rs2_used = 1;
    cycle("lu_stall");
    if (last_out.hold == 2) cnt++;
    bus.i_ex_is_load = 0;
    for (int k = 0; k < 2; k++) begin
      cycle("lu_after");
      if (last_out.hold == 2) cnt++;
    end
    check_int("lu_bubbles", cnt, 1);
    idle();

    // Divide: start then done 33 cycles later.
    cnt = 0;
    bus.i_div_start = 1;
    for (int k = 0; k < 33; k++) begin
      cycle("div_wait");
      bus.i_div_start = 0;
      if (last_out.hold == 3) cnt++;
    end
    bus.i_div_done = 1;
    cycle("div_done");
    check_int("div_done_hold", int'(last_out.hold), 0);
    bus.i_div_done = 0;
    cycle("div_run");
    check_int("div_hold_cycles", cnt, 33);

    // Bus wait interrupted by reset in the third cycle.
    bus.i_mem_req = 1; bus.i_mem_ready = 0;
    cycle("mem_w1");
    cycle("mem_w2");
    rst_n = 0;
    cycle("mem_rst");
    rst_n = 1;
    cycle("mem_w4");
    bus.i_mem_ready = 1;
    cycle("mem_ready");
    idle();
    bus.i_jump_req = 1; bus.i_jump_addr = 32'h0000_0300;
    cycle("mem_run_jump");
    check_int("mem_run_jf", int'(last_out.jf), 1);
    idle();

`ifdef PIPE_CTRL_TIMEOUT_EN
    // Reset mid-wait then a full timeout: bus_err must land on stall cycle 8.
    bus.i_mem_req = 1; bus.i_mem_ready = 0;
    cycle("to_w1");
    rst_n = 0;
    cycle("to_rst");
    rst_n = 1;
    err_at = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle("to_wait");
      bus.i_mem_req = 0;
      if (last_out.err && err_at == 0) err_at = k;
    end
    check_int("to_err_cycle", err_at, 8);
    cycle("to_run");
    check_int("to_released", int'(last_out.hold), 0);
`else
    err_at = 0;
    bus.i_mem_req = 1; bus.i_mem_ready = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle("nto_wait");
      bus.i_mem_req = 0;
      if (last_out.err) err_at = k;
    end
    check_int("nto_no_err", err_at, 0);
    bus.i_mem_ready = 1;
    cycle("nto_ready");
`endif
    idle();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n              = ($urandom_range(0, 79) != 0);
      bus.i_jump_req     = (m_unit == 0) && ($urandom_range(0, 5) == 0);
      bus.i_jump_addr    = $urandom;
      bus.i_ex_is_load   = $urandom_range(0, 1) == 1;
      bus.i_ex_rd_addr   = 5'($urandom_range(0, 3));
      bus.i_id_rs1_addr  = 5'($urandom_range(0, 3));
      bus.i_id_rs2_addr  = 5'($urandom_range(0, 3));
      bus.i_id_rs1_used  = $urandom_range(0, 1) == 1;
      bus.i_id_rs2_used  = $urandom_range(0, 1) == 1;
      bus.i_div_start    = $urandom_range(0, 7) == 0;
      bus.i_div_done     = $urandom_range(0, 5) == 0;
      bus.i_mem_req      = $urandom_range(0, 5) == 0;
      bus.i_mem_ready    = $urandom_range(0, 8) == 0;
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
